prbs_ber_ctrl: RTL and testbench
================================

PRBS_BER_CTRL -- requirements
Module: prbs_ber_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- SEED, 9'h1FE, value the generator reloads on o_gen_reset.
- SYNC_LEN, 16, consecutive matching valid bits needed to declare lock.
- SYNC_TIMEOUT, 1023, valid bits allowed in SYNC before failure.
REQ-002 SHALL have ports (name, direction, width, meaning):
- i_clk, in, 1, single clock; all logic rising-edge.
- i_reset, in, 1, synchronous active-high reset.
- i_start, in, 1, one-cycle pulse that starts a test run.
- i_abort, in, 1, aborts the run.
- i_num_bits, in, 16, post-lock bits to check; sampled at start.
- i_rx_bit, in, 1, received PRBS bit.
- i_rx_valid, in, 1, qualifies i_rx_bit.
- o_gen_reset, out, 1, drives the PRBS9 generator reset (reseed).
- o_gen_enable, out, 1, drives the generator enable.
- o_busy, out, 1, high when the FSM is not in IDLE.
- o_locked, out, 1, high while in RUN.
- o_done, out, 1, one-cycle completion pulse.
- o_sync_fail, out, 1, sticky until next start: lock timeout occurred.
- o_bit_count, out, 16, valid bits checked in RUN.
- o_err_count, out, 16, errors seen in RUN (saturating).

Function
REQ-003 SHALL use polynomial x^9+x^5+1; predicted bit = r[8]^r[4] of a 9-bit checker register r.
REQ-004 SHALL implement FSM states IDLE, LOAD, SYNC, RUN, DONE.
REQ-005 IDLE: on i_start, go to LOAD; latch i_num_bits; clear o_bit_count, o_err_count and o_sync_fail; clear the match and timeout counters.
REQ-006 LOAD SHALL last exactly 1 cycle with o_gen_reset=1 and o_gen_enable=0; then go to SYNC.
REQ-007 o_gen_enable SHALL be 1 in SYNC and RUN, and 0 in all other states.
REQ-008 SYNC, per valid bit:
- r shifts in i_rx_bit (self-synchronising).
- Match = (i_rx_bit == prediction) AND r != 0.
- A match increments the match counter; a mismatch clears it.
- The timeout counter increments on every valid bit.
REQ-009 SYNC SHALL go to RUN on the valid bit that makes the match counter reach SYNC_LEN; if i_num_bits latched 0, it SHALL go to DONE instead.
REQ-010 If the timeout counter reaches SYNC_TIMEOUT without lock, the block SHALL set o_sync_fail and go to DONE.
REQ-011 RUN, per valid bit:
- r free-runs on its own feedback (not on i_rx_bit).
- o_bit_count increments.
- o_err_count increments on i_rx_bit != prediction, saturating at 16'hFFFF.
REQ-012 RUN SHALL go to DONE on the valid bit where o_bit_count reaches the latched i_num_bits.
REQ-013 DONE SHALL last 1 cycle with o_done=1, then go to IDLE; counts and o_sync_fail SHALL hold until the next start.
REQ-014 Cycles with i_rx_valid=0 SHALL change no counter and no r.
REQ-015 i_abort SHALL force IDLE next cycle from any state, with no o_done pulse; counts hold. If i_abort and i_start are asserted together, abort SHALL win.
REQ-016 i_start SHALL be ignored while o_busy=1.

Reset
REQ-017 On i_reset, the block SHALL go to IDLE and clear r, all counters, o_gen_enable, o_done, o_locked and o_sync_fail.
REQ-018 During reset, o_gen_reset SHALL be 1, so the generator is reseeded.
REQ-019 A reset mid-run SHALL discard the run without asserting o_done.

Configuration
REQ-020 With PRBS_FIRST_ERR_EN defined, the block SHALL add output o_first_err_idx[15:0]:
- Holds the o_bit_count value (pre-increment) of the first RUN error.
- Reads 16'hFFFF if no error occurred.
- Cleared to 16'hFFFF on start and on reset.
REQ-021 Without PRBS_FIRST_ERR_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-022 Package prbs_pkg SHALL hold:
- The FSM state encoding.
- PRBS9 ORDER=9 and tap constants (8, 4).
- The 16-bit counter width.
REQ-023 Sub-module prbs9_checker SHALL own r, the sync/free-run mode select, and the per-bit error output.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Loopback: generator into rx, i_rx_valid=1, i_num_bits=1000 -> lock after 16 bits; o_bit_count=1000, o_err_count=0, one o_done pulse.
- Loopback, bit 500 of RUN inverted -> o_err_count=1; with the macro, o_first_err_idx=499.
- i_rx_bit stuck 0 -> no lock; o_sync_fail=1 and o_done after 1023 valid bits; o_bit_count=0.
- i_rx_valid toggled 1/0 each cycle, i_num_bits=100 -> o_bit_count=100 and o_err_count=0, run taking about twice the cycles.
- i_abort in RUN at bit 50 -> IDLE next cycle, no o_done, o_bit_count=50; i_start pulsed during RUN is ignored.
- i_reset asserted in SYNC -> outputs reset and o_gen_reset=1 in that cycle; a new start runs normally.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared constants, FSM encoding and PRBS9 prediction helper for the BER controller.
package prbs_pkg;

   localparam int unsigned ORDER  = 9;
   localparam int unsigned TAP_HI = 8;
   localparam int unsigned TAP_LO = 4;
   localparam int unsigned CNT_W  = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SYNC,
      S_RUN,
      S_DONE
   } state_t;

   // Next PRBS9 bit (x^9 + x^5 + 1) predicted from the last ORDER bits.
   function automatic logic prbs9_pred(input logic [ORDER-1:0] r);
      return r[TAP_HI] ^ r[TAP_LO];
   endfunction

endpackage

// File: rtl/prbs_ber_ctrl_if.sv
// Control/status bundle of the PRBS BER controller.
// PRBS_FIRST_ERR_EN adds the first-error index field.
interface prbs_ber_ctrl_if;
   import prbs_pkg::*;

   logic             i_start;
   logic             i_abort;
   logic [CNT_W-1:0] i_num_bits;
   logic             i_rx_bit;
   logic             i_rx_valid;
   logic             o_gen_reset;
   logic             o_gen_enable;
   logic             o_busy;
   logic             o_locked;
   logic             o_done;
   logic             o_sync_fail;
   logic [CNT_W-1:0] o_bit_count;
   logic [CNT_W-1:0] o_err_count;
`ifdef PRBS_FIRST_ERR_EN
   logic [CNT_W-1:0] o_first_err_idx;
`endif

   modport slave (
`ifdef PRBS_FIRST_ERR_EN
      output o_first_err_idx,
`endif
      input  i_start, i_abort, i_num_bits, i_rx_bit, i_rx_valid,
      output o_gen_reset, o_gen_enable, o_busy, o_locked, o_done,
             o_sync_fail, o_bit_count, o_err_count
   );

   modport master (
`ifdef PRBS_FIRST_ERR_EN
      input  o_first_err_idx,
`endif
      output i_start, i_abort, i_num_bits, i_rx_bit, i_rx_valid,
      input  o_gen_reset, o_gen_enable, o_busy, o_locked, o_done,
             o_sync_fail, o_bit_count, o_err_count
   );

endinterface

// File: rtl/prbs9_checker.sv
// PRBS9 checker register: self-synchronising in SYNC, free-running in RUN.
module prbs9_checker
   import prbs_pkg::*;
#(
   parameter logic [ORDER-1:0] SEED = 9'h1FE
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic shift,
   input  logic free_run,
   input  logic rx_bit,
   output logic bit_err_c,
   output logic r_nonzero_c
);

   logic [ORDER-1:0] r;
   logic             pred;

   assign pred        = prbs9_pred(r);
   assign bit_err_c   = rx_bit != pred;
   assign r_nonzero_c = |r;

   // Preloading the seed lets a clean loopback match from the very first bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r <= '0;
      end else if (load) begin
         r <= SEED;
      end else if (shift) begin
         r <= {r[ORDER-2:0], free_run ? pred : rx_bit};
      end
   end

endmodule

// File: rtl/prbs_ber_ctrl.sv
// PRBS9 bit-error-rate test controller: reseed, lock, count bits and errors.
// Optional PRBS_FIRST_ERR_EN records the bit index of the first RUN error.
module prbs_ber_ctrl
   import prbs_pkg::*;
#(
   parameter logic [ORDER-1:0] SEED         = 9'h1FE,
   parameter int unsigned      SYNC_LEN     = 16,
   parameter int unsigned      SYNC_TIMEOUT = 1023
) (
   input  logic            i_clk,
   input  logic            i_reset,
   prbs_ber_ctrl_if.slave  bus
);

   state_t           state;
   logic [CNT_W-1:0] num_bits_q;
   logic [CNT_W-1:0] bit_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic [CNT_W-1:0] match_cnt;
   logic [CNT_W-1:0] tmo_cnt;
   logic             sync_fail_q;
   logic             bit_err_c;
   logic             r_nonzero_c;
   logic             sync_match_c;
   logic             shift_c;
   logic             load_c;
`ifdef PRBS_FIRST_ERR_EN
   logic [CNT_W-1:0] first_err_q;
`endif

   assign shift_c      = bus.i_rx_valid && !bus.i_abort &&
                         ((state == S_SYNC) || (state == S_RUN));
   assign load_c       = (state == S_IDLE) && bus.i_start && !bus.i_abort;
   assign sync_match_c = !bit_err_c && r_nonzero_c;

   prbs9_checker #(.SEED(SEED)) u_checker (
      .clk        (i_clk),
      .rst        (i_reset),
      .load       (load_c),
      .shift      (shift_c),
      .free_run   (state == S_RUN),
      .rx_bit     (bus.i_rx_bit),
      .bit_err_c  (bit_err_c),
      .r_nonzero_c(r_nonzero_c)
   );

   // Test sequencer and counters; abort beats everything except reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state       <= S_IDLE;
         num_bits_q  <= '0;
         bit_cnt     <= '0;
         err_cnt     <= '0;
         match_cnt   <= '0;
         tmo_cnt     <= '0;
         sync_fail_q <= 1'b0;
`ifdef PRBS_FIRST_ERR_EN
         first_err_q <= '1;
`endif
      end else if (bus.i_abort) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.i_start) begin
                  state       <= S_LOAD;
                  num_bits_q  <= bus.i_num_bits;
                  bit_cnt     <= '0;
                  err_cnt     <= '0;
                  match_cnt   <= '0;
                  tmo_cnt     <= '0;
                  sync_fail_q <= 1'b0;
`ifdef PRBS_FIRST_ERR_EN
                  first_err_q <= '1;
`endif
               end
            end
            S_LOAD: state <= S_SYNC;
            S_SYNC: begin
               if (bus.i_rx_valid) begin
                  match_cnt <= sync_match_c ? CNT_W'(match_cnt + 1'b1) : '0;
                  tmo_cnt   <= CNT_W'(tmo_cnt + 1'b1);
                  // Lock takes precedence over a timeout on the same bit.
                  if (sync_match_c && (match_cnt == CNT_W'(SYNC_LEN - 1))) begin
                     state <= (num_bits_q == '0) ? S_DONE : S_RUN;
                  end else if (tmo_cnt == CNT_W'(SYNC_TIMEOUT - 1)) begin
                     sync_fail_q <= 1'b1;
                     state       <= S_DONE;
                  end
               end
            end
            S_RUN: begin
               if (bus.i_rx_valid) begin
                  bit_cnt <= CNT_W'(bit_cnt + 1'b1);
                  if (bit_err_c && (err_cnt != '1)) begin
                     err_cnt <= CNT_W'(err_cnt + 1'b1);
                  end
`ifdef PRBS_FIRST_ERR_EN
                  if (bit_err_c && (err_cnt == '0)) begin
                     first_err_q <= bit_cnt;
                  end
`endif
                  if (CNT_W'(bit_cnt + 1'b1) == num_bits_q) begin
                     state <= S_DONE;
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Generator reseed is also forced straight from reset so it applies in the reset cycle.
   assign bus.o_gen_reset  = i_reset || (state == S_LOAD);
   assign bus.o_gen_enable = (state == S_SYNC) || (state == S_RUN);
   assign bus.o_busy       = state != S_IDLE;
   assign bus.o_locked     = state == S_RUN;
   assign bus.o_done       = state == S_DONE;
   assign bus.o_sync_fail  = sync_fail_q;
   assign bus.o_bit_count  = bit_cnt;
   assign bus.o_err_count  = err_cnt;
`ifdef PRBS_FIRST_ERR_EN
   assign bus.o_first_err_idx = first_err_q;
`endif

endmodule

// File: tb/tb_prbs_ber_ctrl.sv
// Directed bench for prbs_ber_ctrl: table of whole test runs plus abort/reset sequences.
module tb_prbs_ber_ctrl;
   import prbs_pkg::*;

   localparam logic [8:0] SEED = 9'h1FE;
   localparam int MODE_LOOP   = 0;
   localparam int MODE_STUCK  = 1;
   localparam int MODE_TOGGLE = 2;

   typedef struct {
      int num_bits;
      int mode;
      int inject;
      int exp_bits;
      int exp_errs;
      int exp_sf;
      int exp_sync;
      int run_min;
      int run_max;
      int exp_first;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   prbs_ber_ctrl_if bus();

   prbs_ber_ctrl #(.SEED(SEED), .SYNC_LEN(16), .SYNC_TIMEOUT(1023)) dut (
      .i_clk  (clk),
      .i_reset(rst),
      .bus    (bus)
   );

   // Reference PRBS9 generator driven by the DUT's reseed/enable outputs.
   logic [8:0] g;
   logic       gen_bit;
   logic       stuck0;
   int         inject_idx;

   always @(posedge clk) begin
      if (bus.o_gen_reset) g <= SEED;
      else if (bus.o_gen_enable && bus.i_rx_valid) g <= {g[7:0], g[8] ^ g[4]};
   end
   assign gen_bit = g[8] ^ g[4];
   assign bus.i_rx_bit = stuck0 ? 1'b0 :
      (gen_bit ^ (bus.o_locked && (inject_idx >= 0) && (int'(bus.o_bit_count) == inject_idx)));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_run(input int nb, input int mode, input int inj,
                         output int bc, output int ec, output int sf, output int dones,
                         output int sync_bits, output int run_cyc, output int fe,
                         output int timed_out);
      stuck0           = (mode == MODE_STUCK);
      inject_idx       = inj;
      bus.i_rx_valid   = 1'b1;
      bus.i_num_bits   = 16'(nb);
      bus.i_start      = 1'b1;
      tick();
      bus.i_start      = 1'b0;
      sync_bits = 0;
      run_cyc   = 0;
      dones     = 0;
      timed_out = 1;
      for (int c = 0; c < 5000; c++) begin
         if (mode == MODE_TOGGLE) bus.i_rx_valid = ~bus.i_rx_valid;
         if (bus.o_gen_enable && !bus.o_locked && bus.i_rx_valid) sync_bits++;
         if (bus.o_locked) run_cyc++;
         tick();
         if (bus.o_done) dones++;
         if (!bus.o_busy) begin
            timed_out = 0;
            break;
         end
      end
      for (int c = 0; c < 4; c++) begin
         tick();
         if (bus.o_done) dones++;
      end
      bc = int'(bus.o_bit_count);
      ec = int'(bus.o_err_count);
      sf = int'(bus.o_sync_fail);
`ifdef PRBS_FIRST_ERR_EN
      fe = int'(bus.o_first_err_idx);
`else
      fe = 16'hFFFF;
`endif
      bus.i_rx_valid = 1'b1;
      stuck0         = 1'b0;
      inject_idx     = -1;
   endtask

   task automatic wait_count(input int target, output int ok);
      ok = 0;
      for (int c = 0; c < 3000; c++) begin
         if (int'(bus.o_bit_count) == target) begin
            ok = 1;
            break;
         end
         tick();
      end
   endtask

   vec_t vecs[6];
   int bc, ec, sf, dones, sync_bits, run_cyc, fe, tmo, ok;

   initial begin
      //           nb    mode         inj  bits errs sf sync rmin rmax first
      vecs[0] = '{1000, MODE_LOOP,   -1,  1000, 0,  0, 16,  1000, 1000, 16'hFFFF};
      vecs[1] = '{1000, MODE_LOOP,   499, 1000, 1,  0, 16,  1000, 1000, 499};
      vecs[2] = '{1000, MODE_STUCK,  -1,  0,    0,  1, 1023, 0,   0,    16'hFFFF};
      vecs[3] = '{100,  MODE_TOGGLE, -1,  100,  0,  0, 16,  199,  201,  16'hFFFF};
      vecs[4] = '{0,    MODE_LOOP,   -1,  0,    0,  0, 16,  0,    0,    16'hFFFF};
      vecs[5] = '{1,    MODE_LOOP,   0,   1,    1,  0, 16,  1,    1,    0};

      rst            = 1'b1;
      stuck0         = 1'b0;
      inject_idx     = -1;
      bus.i_start    = 1'b0;
      bus.i_abort    = 1'b0;
      bus.i_rx_valid = 1'b0;
      bus.i_num_bits = '0;
      #1;
      check("gen_reset_in_reset", bus.o_gen_reset, 1);
      tick();
      tick();
      check("rst_busy", bus.o_busy, 0);
      check("rst_locked", bus.o_locked, 0);
      check("rst_done", bus.o_done, 0);
      check("rst_gen_enable", bus.o_gen_enable, 0);
      check("rst_bit_count", bus.o_bit_count, 0);
      check("rst_err_count", bus.o_err_count, 0);
      check("rst_sync_fail", bus.o_sync_fail, 0);
`ifdef PRBS_FIRST_ERR_EN
      check("rst_first_err", bus.o_first_err_idx, 16'hFFFF);
`endif
      rst = 1'b0;
      tick();
      check("idle_gen_reset", bus.o_gen_reset, 0);

      // LOAD lasts one cycle with reseed high and enable low.
      bus.i_rx_valid = 1'b1;
      bus.i_num_bits = 16'd10;
      bus.i_start    = 1'b1;
      tick();
      bus.i_start = 1'b0;
      check("load_gen_reset", bus.o_gen_reset, 1);
      check("load_gen_enable", bus.o_gen_enable, 0);
      check("load_busy", bus.o_busy, 1);
      tick();
      check("sync_gen_reset", bus.o_gen_reset, 0);
      check("sync_gen_enable", bus.o_gen_enable, 1);
      bus.i_abort = 1'b1;
      tick();
      bus.i_abort = 1'b0;
      check("abort_sync_busy", bus.o_busy, 0);

      // Abort wins over a simultaneous start.
      bus.i_abort = 1'b1;
      bus.i_start = 1'b1;
      tick();
      bus.i_abort = 1'b0;
      bus.i_start = 1'b0;
      check("abort_start_busy", bus.o_busy, 0);

      for (int i = 0; i < 6; i++) begin
         do_run(vecs[i].num_bits, vecs[i].mode, vecs[i].inject,
                bc, ec, sf, dones, sync_bits, run_cyc, fe, tmo);
         check($sformatf("v%0d_timeout", i), tmo, 0);
         check($sformatf("v%0d_bit_count", i), bc, vecs[i].exp_bits);
         check($sformatf("v%0d_err_count", i), ec, vecs[i].exp_errs);
         check($sformatf("v%0d_sync_fail", i), sf, vecs[i].exp_sf);
         check($sformatf("v%0d_done_pulses", i), dones, 1);
         check($sformatf("v%0d_sync_bits", i), sync_bits, vecs[i].exp_sync);
         check_range($sformatf("v%0d_run_cycles", i), run_cyc, vecs[i].run_min, vecs[i].run_max);
`ifdef PRBS_FIRST_ERR_EN
         check($sformatf("v%0d_first_err", i), fe, vecs[i].exp_first);
`endif
      end

      // Abort at RUN bit 50; a start pulse during RUN must be ignored.
      bus.i_rx_valid = 1'b1;
      bus.i_num_bits = 16'd1000;
      bus.i_start    = 1'b1;
      tick();
      bus.i_start = 1'b0;
      wait_count(20, ok);
      check("abort_reach_20", ok, 1);
      bus.i_num_bits = 16'd5;
      bus.i_start    = 1'b1;
      tick();
      bus.i_start = 1'b0;
      check("busy_start_locked", bus.o_locked, 1);
      check("busy_start_count", bus.o_bit_count, 21);
      wait_count(50, ok);
      check("abort_reach_50", ok, 1);
      bus.i_abort = 1'b1;
      tick();
      bus.i_abort = 1'b0;
      dones = int'(bus.o_done);
      check("abort_run_busy", bus.o_busy, 0);
      check("abort_run_count", bus.o_bit_count, 50);
      for (int c = 0; c < 3; c++) begin
         tick();
         if (bus.o_done) dones++;
      end
      check("abort_no_done", dones, 0);
      check("abort_count_hold", bus.o_bit_count, 50);

      // Reset while in SYNC, then a fresh run.
      bus.i_num_bits = 16'd200;
      bus.i_start    = 1'b1;
      tick();
      bus.i_start = 1'b0;
      tick();
      tick();
      tick();
      check("pre_reset_in_sync", bus.o_gen_enable && !bus.o_locked, 1);
      rst = 1'b1;
      #1;
      check("reset_sync_gen_reset", bus.o_gen_reset, 1);
      @(posedge clk);
      #1;
      check("reset_sync_busy", bus.o_busy, 0);
      check("reset_sync_enable", bus.o_gen_enable, 0);
      check("reset_sync_done", bus.o_done, 0);
      check("reset_sync_bits", bus.o_bit_count, 0);
      check("reset_sync_gen_reset_hold", bus.o_gen_reset, 1);
      rst = 1'b0;
      tick();
      do_run(200, MODE_LOOP, -1, bc, ec, sf, dones, sync_bits, run_cyc, fe, tmo);
      check("rerun_timeout", tmo, 0);
      check("rerun_bit_count", bc, 200);
      check("rerun_err_count", ec, 0);
      check("rerun_done_pulses", dones, 1);
      check("rerun_sync_bits", sync_bits, 16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
